// File: rtl/neuron_step_sequencer.sv
// neuron_step_sequencer
//
// Shares one Hodgkin-Huxley update datapath among NUM_NEURONS neuron
// contexts kept in an external context store. Each integration-step request
// walks every neuron index in order: read the context, start the datapath,
// wait for completion, write the result back and record the spike bit.
// At the end of a step it publishes the collected spike vector and bumps the
// step counter.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   step_req     request one integration step (level, sampled every cycle)
//   clear_err    clears the sticky error flags
//   ctx_rd_en    context-store read strobe (data valid the following cycle)
//   ctx_wr_en    context-store write strobe (datapath result)
//   ctx_idx      neuron index for read/write, 0 while idle
//   dp_start     one-cycle start pulse to the HH datapath
//   dp_done      datapath completion pulse
//   dp_spike     spike result, valid with dp_done
//   busy         high whenever the sequencer is not idle
//   step_done    one-cycle pulse at step completion
//   spike_vec    spike bits of the last completed step
//   step_count   completed steps, wraps modulo 2^STEP_W
//   err_timeout  sticky: a neuron update timed out
//   err_overrun  sticky: a request arrived while one was already pending
//
// All outputs come straight from flops; the output process computes their
// next values from the next state.

module neuron_step_sequencer #(
  parameter int NUM_NEURONS = 4,
  parameter int IDX_W       = 2,
  parameter int TIMEOUT     = 63,
  parameter int STEP_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   step_req,
  input  logic                   clear_err,
  output logic                   ctx_rd_en,
  output logic                   ctx_wr_en,
  output logic [IDX_W-1:0]       ctx_idx,
  output logic                   dp_start,
  input  logic                   dp_done,
  input  logic                   dp_spike,
  output logic                   busy,
  output logic                   step_done,
  output logic [NUM_NEURONS-1:0] spike_vec,
  output logic [STEP_W-1:0]      step_count,
  output logic                   err_timeout,
  output logic                   err_overrun
);

  // The wait counter only has to hold 0..TIMEOUT-1: the TIMEOUT-th WAIT
  // cycle is recognised while the counter reads TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_NEURONS - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_WAIT,
    S_WRITE,
    S_NEXT
  } state_t;

  state_t                 state;
  state_t                 state_nx;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_nx;
  logic                   pending;
  logic                   pending_nx;
  logic [CNT_W-1:0]       wait_cnt;
  logic [NUM_NEURONS-1:0] acc;

  // Events decoded by the next-state logic
  logic start_step;    // entering FETCH for index 0 of a new step
  logic step_end;      // leaving the NEXT state of the last neuron
  logic wait_done;     // datapath completed in WAIT
  logic wait_timeout;  // WAIT expired without completion
  logic overrun_evt;   // request dropped because one is already pending

  // Next values of the registered outputs
  logic             busy_d;
  logic             rd_d;
  logic             wr_d;
  logic             start_d;
  logic [IDX_W-1:0] idx_out_d;
  logic             err_to_d;
  logic             err_ov_d;

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      pending     <= 1'b0;
      busy        <= 1'b0;
      ctx_rd_en   <= 1'b0;
      ctx_wr_en   <= 1'b0;
      dp_start    <= 1'b0;
      ctx_idx     <= '0;
      step_done   <= 1'b0;
      spike_vec   <= '0;
      step_count  <= '0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      pending     <= pending_nx;
      busy        <= busy_d;
      ctx_rd_en   <= rd_d;
      ctx_wr_en   <= wr_d;
      dp_start    <= start_d;
      ctx_idx     <= idx_out_d;
      step_done   <= step_end;
      err_timeout <= err_to_d;
      err_overrun <= err_ov_d;
      if (step_end) begin
        spike_vec  <= acc;
        step_count <= step_count + STEP_W'(1);
      end
    end
  end

  // Spike accumulator and WAIT counter. Both are re-initialised before use
  // (accumulator at step start, counter in START), so they need no reset.
  // On the completing edge spike_vec takes the old accumulator value while
  // a back-to-back restart clears it.
  always_ff @(posedge clk) begin
    if (start_step) begin
      acc <= '0;
    end else if (wait_done) begin
      acc[idx] <= dp_spike;
    end
    if (state == S_START) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    start_step   = 1'b0;
    step_end     = 1'b0;
    wait_done    = 1'b0;
    wait_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        if (step_req || pending) begin
          state_nx   = S_FETCH;
          idx_nx     = '0;
          start_step = 1'b1;
        end
      end
      S_FETCH: state_nx = S_START;
      S_START: state_nx = S_WAIT;
      S_WAIT: begin
        // Completion wins over a timeout on the same cycle.
        if (dp_done) begin
          wait_done = 1'b1;
          state_nx  = S_WRITE;
        end else if (wait_cnt == WAIT_LAST) begin
          wait_timeout = 1'b1;
          state_nx     = S_NEXT;
        end
      end
      S_WRITE: state_nx = S_NEXT;
      S_NEXT: begin
        if (idx == LAST_IDX) begin
          step_end = 1'b1;
          idx_nx   = '0;
          if (pending) begin
            state_nx   = S_FETCH;
            start_step = 1'b1;
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          idx_nx   = idx + IDX_W'(1);
          state_nx = S_FETCH;
        end
      end
      default: begin
        state_nx = S_IDLE;
        idx_nx   = '0;
      end
    endcase

    // One-deep request queue. Starting a step consumes the pending request;
    // a request seen on that same edge while still busy becomes the new
    // pending one rather than an overrun.
    overrun_evt = step_req && pending && !start_step;
    if (start_step) begin
      pending_nx = (state != S_IDLE) && step_req;
    end else begin
      pending_nx = pending || (step_req && (state != S_IDLE));
    end
  end

  // Output logic
  always_comb begin
    busy_d    = (state_nx != S_IDLE);
    rd_d      = (state_nx == S_FETCH);
    start_d   = (state_nx == S_START);
    wr_d      = (state_nx == S_WRITE);
    idx_out_d = (state_nx == S_IDLE) ? '0 : idx_nx;
    // A same-cycle error beats the clear.
    if (wait_timeout) begin
      err_to_d = 1'b1;
    end else if (clear_err) begin
      err_to_d = 1'b0;
    end else begin
      err_to_d = err_timeout;
    end
    if (overrun_evt) begin
      err_ov_d = 1'b1;
    end else if (clear_err) begin
      err_ov_d = 1'b0;
    end else begin
      err_ov_d = err_overrun;
    end
  end

endmodule

// File: tb/tb_neuron_step_sequencer.sv
// Testbench for neuron_step_sequencer. The datapath is emulated by a
// responder that answers each dp_start after a chosen latency; expected
// behaviour (step length, spike vector, write-back order, error flags,
// step counter) is computed from per-neuron latencies and spike choices.

module tb_neuron_step_sequencer;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int TO = 63;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          step_req = 1'b0;
  logic          clear_err = 1'b0;
  logic          dp_done = 1'b0;
  logic          dp_spike = 1'b0;
  logic          ctx_rd_en;
  logic          ctx_wr_en;
  logic [IW-1:0] ctx_idx;
  logic          dp_start;
  logic          busy;
  logic          step_done;
  logic [N-1:0]  spike_vec;
  logic [SW-1:0] step_count;
  logic          err_timeout;
  logic          err_overrun;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  int exp_count  = 0;
  bit exp_err_to = 1'b0;
  bit exp_err_ov = 1'b0;

  // Per-neuron stimulus: latency in WAIT cycles (0 = never completes), spike
  int lat [N];
  bit spk [N];

  neuron_step_sequencer #(
    .NUM_NEURONS(N),
    .IDX_W      (IW),
    .TIMEOUT    (TO),
    .STEP_W     (SW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .step_req   (step_req),
    .clear_err  (clear_err),
    .ctx_rd_en  (ctx_rd_en),
    .ctx_wr_en  (ctx_wr_en),
    .ctx_idx    (ctx_idx),
    .dp_start   (dp_start),
    .dp_done    (dp_done),
    .dp_spike   (dp_spike),
    .busy       (busy),
    .step_done  (step_done),
    .spike_vec  (spike_vec),
    .step_count (step_count),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got hang required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_strobes"}, {ctx_rd_en, ctx_wr_en, dp_start, step_done}, 0);
    chk({tag, "_idx"}, ctx_idx, 0);
  endtask

  // One step requested from idle; checks everything against the model.
  task automatic run_step(input string tag, input bit hold_clear);
    int exp_len;
    int to_cnt;
    logic [N-1:0] vec;
    int rd_q[$];
    int wr_q[$];
    int wr_exp[$];
    int starts;
    int busy_cyc;
    int done_cyc;
    int err_hi;
    int done_at;
    int sn;
    bit spike_cur;

    exp_len = 1;
    to_cnt  = 0;
    vec     = '0;
    for (int i = 0; i < N; i++) begin
      if (lat[i] >= 1 && lat[i] <= TO) begin
        exp_len += 4 + lat[i];
        vec[i] = spk[i];
        wr_exp.push_back(i);
      end else begin
        exp_len += 3 + TO;
        to_cnt++;
      end
    end

    starts = 0; busy_cyc = 0; done_cyc = -1; err_hi = 0;
    done_at = -1; sn = 0; spike_cur = 1'b0;
    for (int k = 0; k <= exp_len + 10; k++) begin
      if (ctx_rd_en) rd_q.push_back(int'(ctx_idx));
      if (ctx_wr_en) wr_q.push_back(int'(ctx_idx));
      if (busy) busy_cyc++;
      if (k > 0 && err_timeout) err_hi++;
      if (dp_start) begin
        if (sn < N && lat[sn] >= 1) done_at = k + lat[sn];
        else done_at = -1;
        spike_cur = (sn < N) ? spk[sn] : 1'b0;
        sn++;
        starts++;
      end
      if (step_done) begin
        done_cyc = k;
        break;
      end
      step_req  = (k == 0);
      clear_err = hold_clear;
      dp_done   = (k == done_at);
      dp_spike  = (k == done_at) ? spike_cur : 1'($urandom_range(0, 1));
      next_cycle();
    end
    step_req = 1'b0; clear_err = 1'b0; dp_done = 1'b0;

    chk({tag, "_done_cycle"}, done_cyc, exp_len);
    chk({tag, "_spike_vec"}, spike_vec, vec);
    exp_count = (exp_count + 1) % (1 << SW);
    chk({tag, "_step_count"}, step_count, exp_count);
    chk({tag, "_starts"}, starts, N);
    chk({tag, "_busy_cycles"}, busy_cyc, exp_len - 1);
    chk({tag, "_rd_count"}, rd_q.size(), N);
    for (int i = 0; i < rd_q.size() && i < N; i++)
      chk({tag, "_rd_idx"}, rd_q[i], i);
    chk({tag, "_wr_count"}, wr_q.size(), wr_exp.size());
    for (int i = 0; i < wr_q.size() && i < wr_exp.size(); i++)
      chk({tag, "_wr_idx"}, wr_q[i], wr_exp[i]);
    if (hold_clear) begin
      // With clear held, each timeout shows for exactly one cycle.
      chk({tag, "_err_pulses"}, err_hi, to_cnt);
      exp_err_to = 1'b0;
      exp_err_ov = 1'b0;
    end else begin
      exp_err_to = exp_err_to | (to_cnt > 0);
    end
    chk({tag, "_err_timeout"}, err_timeout, exp_err_to);
    chk({tag, "_err_overrun"}, err_overrun, exp_err_ov);
    next_cycle();
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    next_cycle();
    clear_err = 1'b0;
    exp_err_to = 1'b0;
    exp_err_ov = 1'b0;
    chk("clear_err_timeout", err_timeout, 0);
    chk("clear_err_overrun", err_overrun, 0);
  endtask

  // step_req held high through cycle 50: four back-to-back steps.
  task automatic run_b2b();
    int dones[$];
    logic [N-1:0] vec_q[$];
    logic [N-1:0] cur_vec;
    int busy_cyc;
    int done_at;
    int sn;
    bit spike_cur;
    logic [N-1:0] v;

    busy_cyc = 0; done_at = -1; sn = 0; spike_cur = 1'b0; cur_vec = '0;
    for (int k = 0; k <= 110; k++) begin
      if (k >= 1 && busy) busy_cyc++;
      if (step_done) begin
        dones.push_back(k);
        exp_count = (exp_count + 1) % (1 << SW);
        chk("b2b_step_count", step_count, exp_count);
        v = (vec_q.size() > 0) ? vec_q.pop_front() : '0;
        chk("b2b_spike_vec", spike_vec, v);
      end
      if (dp_start) begin
        done_at   = k + 1;
        spike_cur = 1'($urandom_range(0, 1));
        cur_vec[sn % N] = spike_cur;
        if (sn % N == N - 1) begin
          vec_q.push_back(cur_vec);
          cur_vec = '0;
        end
        sn++;
      end
      step_req = (k <= 50);
      dp_done  = (k == done_at);
      dp_spike = (k == done_at) ? spike_cur : 1'b0;
      next_cycle();
    end
    step_req = 1'b0; dp_done = 1'b0;
    chk("b2b_num_steps", dones.size(), 4);
    for (int i = 0; i < dones.size(); i++)
      chk("b2b_done_cycle", dones[i], 21 + 20 * i);
    chk("b2b_busy_cycles", busy_cyc, 80);
    exp_err_ov = 1'b1;
    chk("b2b_err_overrun", err_overrun, 1);
    chk("b2b_err_timeout", err_timeout, exp_err_to);
    chk("b2b_wrapped_count", step_count, 0);
  endtask

  initial begin
    int done_at;
    int sn;
    int strobes;

    // Reset
    rst_n = 1'b0;
    repeat (2) next_cycle();
    rst_n = 1'b1;
    check_idle_outputs("reset");
    chk("reset_spike_vec", spike_vec, 0);
    chk("reset_step_count", step_count, 0);
    chk("reset_errs", {err_timeout, err_overrun}, 0);

    // Stray dp_done while idle
    dp_done = 1'b1; dp_spike = 1'b1;
    repeat (5) next_cycle();
    dp_done = 1'b0; dp_spike = 1'b0;
    next_cycle();
    check_idle_outputs("stray_done");
    chk("stray_done_count", step_count, 0);
    chk("stray_done_vec", spike_vec, 0);

    // Basic step: spikes for idx 1 and 3
    lat = '{1, 1, 1, 1};
    spk = '{0, 1, 0, 1};
    run_step("basic", 1'b0);
    chk("basic_vec_const", spike_vec, 4'b1010);

    // Timeout on idx 2, flag sticky until cleared
    lat = '{1, 1, 0, 1};
    spk = '{1, 1, 1, 1};
    run_step("timeout", 1'b0);
    repeat (3) next_cycle();
    chk("timeout_sticky", err_timeout, 1);
    pulse_clear();

    // Timeout while clear_err is held: set wins for one cycle
    lat = '{2, 0, 3, 1};
    spk = '{1, 0, 1, 1};
    run_step("timeout_clr", 1'b1);

    // dp_done on the last allowed WAIT cycle counts as completion
    lat = '{TO, 1, 1, 1};
    spk = '{1, 0, 0, 1};
    run_step("edge_done", 1'b0);
    chk("edge_done_no_err", err_timeout, 0);

    // Randomised steps
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < N; i++) begin
        lat[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8));
        spk[i] = 1'($urandom_range(0, 1));
      end
      run_step("random", 1'($urandom_range(0, 1)));
    end

    // Reset during WAIT of idx 1
    lat = '{1, 30, 1, 1};
    done_at = -1; sn = 0;
    for (int k = 0; k <= 10; k++) begin
      if (dp_start) begin
        done_at = k + lat[sn];
        sn++;
      end
      if (k == 10) begin
        chk("rst_mid_busy", busy, 1);
        chk("rst_mid_idx", ctx_idx, 1);
      end
      step_req = (k == 0);
      dp_done  = (k == done_at);
      dp_spike = 1'b1;
      rst_n    = (k != 10);
      next_cycle();
    end
    rst_n = 1'b1; dp_done = 1'b0; dp_spike = 1'b0;
    exp_count = 0; exp_err_to = 1'b0; exp_err_ov = 1'b0;
    check_idle_outputs("rst_mid");
    chk("rst_mid_spike_vec", spike_vec, 0);
    chk("rst_mid_step_count", step_count, 0);
    chk("rst_mid_errs", {err_timeout, err_overrun}, 0);
    strobes = 0;
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      strobes += int'(ctx_rd_en) + int'(ctx_wr_en) + int'(dp_start) + int'(busy);
    end
    chk("rst_mid_quiet", strobes, 0);

    // Held request: back-to-back steps, overrun, counter wrap
    run_b2b();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/neuron_step_sequencer.md
# neuron_step_sequencer

Time-multiplexing controller that shares one Hodgkin-Huxley update datapath among `NUM_NEURONS` neuron contexts held in an external context store. On each integration-step request it walks every neuron index in order: read context, start the datapath, wait for completion, write back, record the spike. It sits between the top-level step/tick logic and the shared HH datapath, and publishes a per-step spike vector for the STDP synapse stage.

## Interface
Parameters:
- `NUM_NEURONS`, 4: neuron contexts sequenced per step (≥2)
- `IDX_W`, 2: index width, ≥ clog2(NUM_NEURONS)
- `TIMEOUT`, 63: maximum WAIT cycles per neuron before abort (≥1)
- `STEP_W`, 16: step counter width

Ports:
- `clk`  in  1  clock; all logic on the rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `step_req`  in  1  request one integration step (level, sampled every cycle)
- `clear_err`  in  1  clears sticky error flags
- `ctx_rd_en`  out  1  context-store read strobe; data valid the next cycle
- `ctx_wr_en`  out  1  context-store write strobe (datapath result)
- `ctx_idx`  out  IDX_W  neuron index for read/write
- `dp_start`  out  1  one-cycle start pulse to the HH datapath
- `dp_done`  in  1  datapath completion pulse
- `dp_spike`  in  1  spike result, valid with `dp_done`
- `busy`  out  1  high whenever the FSM is not IDLE
- `step_done`  out  1  one-cycle pulse at step completion
- `spike_vec`  out  NUM_NEURONS  spike bits of the last completed step
- `step_count`  out  STEP_W  completed steps, wraps modulo 2^STEP_W
- `err_timeout`  out  1  sticky: a neuron update timed out
- `err_overrun`  out  1  sticky: a request arrived while one was already pending

## Operation
- FSM states: IDLE, FETCH, START, WAIT, WRITE, NEXT.
- IDLE: `busy`=0. A request (`step_req`=1 or a pending request) moves to FETCH with idx=0 and clears the spike accumulator.
- FETCH: `ctx_rd_en`=1, `ctx_idx`=idx; moves to START.
- START: `dp_start`=1 (context data is valid this cycle); clears the WAIT counter; moves to WAIT.
- WAIT: counts cycles 1,2,…
  - `dp_done`=1: latch `dp_spike` into accumulator bit idx, move to WRITE. `dp_done` has priority over timeout on the same cycle.
  - Counter reaches TIMEOUT with no `dp_done`: set `err_timeout`, accumulator bit stays 0, skip WRITE, move to NEXT.
- WRITE: `ctx_wr_en`=1, `ctx_idx`=idx; moves to NEXT.
- NEXT:
  - idx==NUM_NEURONS-1: go to IDLE, or directly to FETCH with idx=0 if a request is pending (pending then clears).
  - Otherwise: idx+1, go to FETCH.
- Step completion (last NEXT): next edge loads `spike_vec` from the accumulator (including a bit latched in the final WAIT), increments `step_count`, and pulses `step_done`.
- Pending request: one-deep. `step_req`=1 while `busy` sets pending. `step_req`=1 while pending is already set sets `err_overrun`; the extra request is dropped.
- `dp_done` outside WAIT is ignored.
- `ctx_idx` holds idx in all non-IDLE states and is 0 in IDLE.
- `clear_err`=1 clears both error flags. A same-cycle error set wins over the clear.

## Timing
- Reset (`rst_n`=0 at an edge) values: state IDLE, idx 0, pending 0, all strobes 0, `busy` 0, `step_done` 0, `spike_vec` 0, `step_count` 0, both error flags 0.
  - Reset mid-step aborts with no further strobes.
  - The accumulator is discarded; `spike_vec` and `step_count` are not updated by the aborted step.
- Per-neuron time: 4 + W cycles, where W = WAIT cycles (W≥1). Timeout path: 3 + TIMEOUT.
- Step latency: `step_req` sampled at edge 0 puts `ctx_rd_en` high in cycle 1.
  - With `dp_done` one cycle after every `dp_start`, `step_done` is high in cycle 5·NUM_NEURONS+1.
  - `busy` is high from cycle 1 through cycle 5·NUM_NEURONS.
- Back-to-back: with a pending request, FETCH for the next step coincides with `step_done`; there are no idle cycles.
- All outputs are registered.

## Test plan
- Basic step, NUM_NEURONS=4, 1-cycle `dp_done`, `dp_spike`=1 for idx 1 and 3 only -> `spike_vec`=4'b1010, `step_count`=1, `step_done` in cycle 21, exactly 4 `dp_start`, 4 `ctx_rd_en` and 4 `ctx_wr_en` pulses with `ctx_idx` 0,1,2,3.
- Timeout: `dp_done` never asserted for idx 2, TIMEOUT=63 -> 63 WAIT cycles, no `ctx_wr_en` for idx 2, bit 2 of `spike_vec`=0, `err_timeout`=1 until `clear_err`, remaining neurons still processed.
- Pending and overrun: hold `step_req`=1 continuously -> steps run back-to-back, `step_done` every 20 cycles, `step_count` increments each time, `err_overrun`=1.
- Reset mid-step: assert `rst_n`=0 during WAIT of idx 1 -> next cycle all outputs at reset values, `spike_vec`=0, `step_count`=0, no strobes.
- Simultaneous events and wrap:
  - `dp_done` on WAIT cycle TIMEOUT -> treated as done, `err_timeout` stays 0.
  - `step_count` preset path (STEP_W=2) after 4 steps -> `step_count`=0.
  - Stray `dp_done` in IDLE -> no effect.
